// File: rtl/hyper_pkg.sv
// Shared definitions for the HyperRAM arbiter: sequencer state encoding and
// read-length normalisation.
package hyper_pkg;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StIssue    = 2'd1;
    localparam logic [1:0] StWaitBusy = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    // hyper_xface has no notion of a zero-length read, so 0 means one dword
    function automatic logic [5:0] norm_nwords(input logic [5:0] nwords);
        return (nwords == 6'd0) ? 6'd1 : nwords;
    endfunction

endpackage

// File: rtl/hyper_arbiter_if.sv
// One requester port of the HyperRAM arbiter: request fields, accept pulse,
// returned read dwords and completion pulse.
interface hyper_arbiter_if;

    logic        valid;
    logic        ready;
    logic        we;
    logic        reg_sel;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [5:0]  nwords;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;

    modport master (
        output valid, we, reg_sel, addr, wd, be, nwords,
        input  ready, rd_valid, rd_data, done
    );

    modport slave (
        input  valid, we, reg_sel, addr, wd, be, nwords,
        output ready, rd_valid, rd_data, done
    );

endinterface

// File: rtl/hyper_arbiter_rr_arb2.sv
// Two-way round-robin grant; the priority pointer flips only when both
// requesters contend while arbitration is enabled.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic rr_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q <= 1'b0;
        end else if (en && (&req)) begin
            rr_q <= ~rr_q;
        end
    end

endmodule

// File: rtl/hyper_arbiter.sv
// Two-port arbiter/sequencer in front of hyper_xface: grants round-robin,
// issues the one-cycle strobe, routes read dwords and holds until busy drops.
module hyper_arbiter
    import hyper_pkg::*;
#(
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    hyper_arbiter_if.slave       p0,
    hyper_arbiter_if.slave       p1,
    output logic                 err,
    output logic                 hr_rd_req,
    output logic                 hr_wr_req,
    output logic [31:0]          hr_addr,
    output logic [31:0]          hr_wr_d,
    output logic [3:0]           hr_wr_byte_en,
    output logic [5:0]           hr_rd_num_dwords,
    output logic                 hr_mem_or_reg,
    input  logic                 hr_busy,
    input  logic                 hr_rd_rdy,
    input  logic [31:0]          hr_rd_d
);

    localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(BUSY_TIMEOUT);

    logic [1:0]      state_q;
    logic            owner_q;
    logic            we_q;
    logic [5:0]      rd_left_q;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      ready_q;
    logic [1:0]      rd_valid_q;
    logic [1:0]      done_q;
    logic [31:0]     rd_data0_q;
    logic [31:0]     rd_data1_q;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        arb_en;
    logic        sel;
    logic        sel_we;
    logic        sel_reg;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;
    logic [3:0]  sel_be;
    logic [5:0]  sel_nw;
    logic        fwd;

    assign req    = {p1.valid, p0.valid};
    assign arb_en = (state_q == StIdle);
    assign sel    = gnt[1];

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rstn (rstn),
        .req  (req),
        .en   (arb_en),
        .gnt  (gnt)
    );

    always_comb begin
        if (sel) begin
            sel_we   = p1.we;
            sel_reg  = p1.reg_sel;
            sel_addr = p1.addr;
            sel_wd   = p1.wd;
            sel_be   = p1.be;
            sel_nw   = p1.nwords;
        end else begin
            sel_we   = p0.we;
            sel_reg  = p0.reg_sel;
            sel_addr = p0.addr;
            sel_wd   = p0.wd;
            sel_be   = p0.be;
            sel_nw   = p0.nwords;
        end
    end

    // Read dwords are only meaningful while a transaction owns the bus
    assign fwd = hr_rd_rdy && ((state_q == StWaitBusy) || (state_q == StWaitDone));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= StIdle;
            owner_q          <= 1'b0;
            we_q             <= 1'b0;
            rd_left_q        <= 6'd0;
            cnt_q            <= '0;
            ready_q          <= 2'b00;
            rd_valid_q       <= 2'b00;
            done_q           <= 2'b00;
            rd_data0_q       <= 32'd0;
            rd_data1_q       <= 32'd0;
            err              <= 1'b0;
            hr_rd_req        <= 1'b0;
            hr_wr_req        <= 1'b0;
            hr_addr          <= 32'd0;
            hr_wr_d          <= 32'd0;
            hr_wr_byte_en    <= 4'd0;
            hr_rd_num_dwords <= 6'd0;
            hr_mem_or_reg    <= 1'b0;
        end else begin
            ready_q    <= 2'b00;
            rd_valid_q <= 2'b00;
            done_q     <= 2'b00;
            err        <= 1'b0;
            hr_rd_req  <= 1'b0;
            hr_wr_req  <= 1'b0;

            if (fwd) begin
                rd_valid_q[owner_q] <= 1'b1;
                if (owner_q) begin
                    rd_data1_q <= hr_rd_d;
                end else begin
                    rd_data0_q <= hr_rd_d;
                end
                if (rd_left_q != 6'd0) begin
                    rd_left_q <= rd_left_q - 6'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (|gnt) begin
                        ready_q          <= gnt;
                        owner_q          <= sel;
                        we_q             <= sel_we;
                        hr_addr          <= sel_addr;
                        hr_wr_d          <= sel_wd;
                        hr_wr_byte_en    <= sel_be;
                        hr_mem_or_reg    <= sel_reg;
                        hr_rd_num_dwords <= norm_nwords(sel_nw);
                        rd_left_q        <= norm_nwords(sel_nw);
                        state_q          <= StIssue;
                    end
                end
                StIssue: begin
                    hr_wr_req <= we_q;
                    hr_rd_req <= ~we_q;
                    cnt_q     <= '0;
                    state_q   <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (hr_busy) begin
                        state_q <= StWaitDone;
                    end else if (cnt_q == CntMax) begin
                        err             <= 1'b1;
                        done_q[owner_q] <= 1'b1;
                        state_q         <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    // A dword arriving as busy falls is forwarded first so done trails it
                    if (!hr_busy && !hr_rd_rdy) begin
                        done_q[owner_q] <= 1'b1;
                        state_q         <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign p0.ready    = ready_q[0];
    assign p1.ready    = ready_q[1];
    assign p0.rd_valid = rd_valid_q[0];
    assign p1.rd_valid = rd_valid_q[1];
    assign p0.rd_data  = rd_data0_q;
    assign p1.rd_data  = rd_data1_q;
    assign p0.done     = done_q[0];
    assign p1.done     = done_q[1];

endmodule
